// File: rtl/alu_seq_nbit_if.sv
// Request/result bundle for the sequential ALU.
// master drives operands and start; slave returns results, flags and status.
interface alu_seq_nbit_if #(
    parameter int unsigned n = 8
);
    logic         start;
    logic [3:0]   ctrl;
    logic [n-1:0] in0;
    logic [n-1:0] in1;
    logic         c_in;
    logic [n-1:0] alu_out;
    logic [n-1:0] hi_out;
    logic         c_out;
    logic         V;
    logic         Z;
    logic         N_flag;
    logic         busy;
    logic         done;

    modport master (
        output start, ctrl, in0, in1, c_in,
        input  alu_out, hi_out, c_out, V, Z, N_flag, busy, done
    );

    modport slave (
        input  start, ctrl, in0, in1, c_in,
        output alu_out, hi_out, c_out, V, Z, N_flag, busy, done
    );
endinterface

// File: rtl/alu_seq_nbit.sv
// n-bit ALU: single-cycle arithmetic/logic/shift ops plus an n-step shift-add
// unsigned multiply producing a 2n-bit product.
module alu_seq_nbit #(
    parameter int unsigned n = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_nbit_if.slave bus
);
    localparam int unsigned W1 = n + 1;
    localparam int unsigned W2 = 2 * n;
    localparam int unsigned CW = $clog2(n + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_ORN  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_ANDN = 4'd5;
    localparam logic [3:0] OP_NOT0 = 4'd6;
    localparam logic [3:0] OP_NOT1 = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W2-1:0] prod_q;
    logic [W2-1:0] mcand_q;
    logic [n-1:0]  mplier_q;

    logic [n-1:0]  alu_q;
    logic [n-1:0]  hi_q;
    logic          c_q;
    logic          v_q;
    logic          z_q;
    logic          neg_q;
    logic          busy_q;
    logic          done_q;

    logic [n-1:0]  add_b;
    logic          add_cin;
    logic [W1-1:0] add_full;
    logic [n-1:0]  res_d;
    logic          cout_d;
    logic          v_d;
    logic [W2-1:0] prod_d;

    // Single-cycle result; SUB reuses the adder with inverted in1 and carry-in 1.
    always_comb begin
        add_b    = (bus.ctrl == OP_SUB) ? ~bus.in1 : bus.in1;
        add_cin  = (bus.ctrl == OP_SUB) ? 1'b1 : bus.c_in;
        add_full = {1'b0, bus.in0} + {1'b0, add_b} + W1'(add_cin);
        res_d    = '0;
        cout_d   = 1'b0;
        v_d      = 1'b0;
        case (bus.ctrl)
            OP_ADD, OP_SUB: begin
                res_d  = add_full[n-1:0];
                cout_d = add_full[n];
                // carry into the MSB recovered from the MSB sum bit
                v_d    = bus.in0[n-1] ^ add_b[n-1] ^ add_full[n-1] ^ add_full[n];
            end
            OP_OR:   res_d = bus.in0 | bus.in1;
            OP_ORN:  res_d = bus.in0 | ~bus.in1;
            OP_AND:  res_d = bus.in0 & bus.in1;
            OP_ANDN: res_d = bus.in0 & ~bus.in1;
            OP_NOT0: res_d = ~bus.in0;
            OP_NOT1: res_d = ~bus.in1;
            OP_SHL: begin
                res_d  = {bus.in0[n-2:0], 1'b0};
                cout_d = bus.in0[n-1];
            end
            OP_SRA: begin
                res_d  = {bus.in0[n-1], bus.in0[n-1:1]};
                cout_d = bus.in0[0];
            end
            default: ;
        endcase
    end

    // One shift-add step: multiplicand shifts left as multiplier shifts right.
    always_comb begin
        prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            alu_q    <= '0;
            hi_q     <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b1;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.ctrl == OP_MUL) begin
                            state_q  <= MUL;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            prod_q   <= '0;
                            mcand_q  <= {{n{1'b0}}, bus.in0};
                            mplier_q <= bus.in1;
                        end else begin
                            alu_q  <= res_d;
                            hi_q   <= '0;
                            c_q    <= cout_d;
                            v_q    <= v_d;
                            z_q    <= (res_d == '0);
                            neg_q  <= res_d[n-1];
                            done_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(n - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        alu_q   <= prod_d[n-1:0];
                        hi_q    <= prod_d[W2-1:n];
                        c_q     <= |prod_d[W2-1:n];
                        v_q     <= 1'b0;
                        z_q     <= (prod_d == '0);
                        neg_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_out = alu_q;
    assign bus.hi_out  = hi_q;
    assign bus.c_out   = c_q;
    assign bus.V       = v_q;
    assign bus.Z       = z_q;
    assign bus.N_flag  = neg_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
